// File: rtl/rainbow_colour_gen.sv
// Rainbow test-pattern pixel generator: hue ramp from X, brightness fade from Y,
// two-stage valid/ready pipeline with start-of-frame and end-of-line markers.
module rainbow_colour_gen #(
  parameter int LINE_LAST = 1023,
  parameter bit BRIGHT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser
);

  logic       w_advance;
  logic [2:0] w_seg;
  logic [7:0] w_r, w_nr;
  logic [7:0] w_hue_r, w_hue_g, w_hue_b;
  logic [8:0] w_k;

  logic       r_s1_valid;
  logic [7:0] r_s1_r, r_s1_g, r_s1_b;
  logic [8:0] r_s1_k;
  logic       r_s1_last, r_s1_sof;

  // Whole pipeline stalls together when the sink refuses a valid beat.
  assign w_advance = !m_tvalid || m_tready;
  assign in_ready  = w_advance;

  assign w_seg = x_in[9:7];
  assign w_r   = {x_in[6:0], 1'b0};
  assign w_nr  = 8'd255 - w_r;
  assign w_k   = BRIGHT_EN ? (9'd256 - {1'b0, y_in[9:2]}) : 9'd256;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held,
    // which would otherwise infer a latch.
    w_hue_r = 8'd0;
    w_hue_g = 8'd0;
    w_hue_b = 8'd0;
    unique case (w_seg)
      3'd0: begin w_hue_r = 8'd255; w_hue_g = w_r;    end
      3'd1: begin w_hue_r = w_nr;   w_hue_g = 8'd255; end
      3'd2: begin w_hue_g = 8'd255; w_hue_b = w_r;    end
      3'd3: begin w_hue_g = w_nr;   w_hue_b = 8'd255; end
      3'd4: begin w_hue_r = w_r;    w_hue_b = 8'd255; end
      3'd5: begin w_hue_r = 8'd255; w_hue_b = w_nr;   end
      3'd6: begin w_hue_r = w_r;    w_hue_g = w_r;    w_hue_b = w_r;  end
      3'd7: begin w_hue_r = w_nr;   w_hue_g = w_nr;   w_hue_b = w_nr; end
      default: ;
    endcase
  end

  // c * k never exceeds 255 * 256, so bits [15:8] always fit in 8 bits.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] k);
    logic [16:0] p;
    p = 17'(c) * 17'(k);
    return 8'(p >> 8);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_r     <= 8'd0;
      r_s1_g     <= 8'd0;
      r_s1_b     <= 8'd0;
      r_s1_k     <= 9'd0;
      r_s1_last  <= 1'b0;
      r_s1_sof   <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_r    <= w_hue_r;
        r_s1_g    <= w_hue_g;
        r_s1_b    <= w_hue_b;
        r_s1_k    <= w_k;
        r_s1_last <= (x_in == 10'(LINE_LAST));
        r_s1_sof  <= (x_in == 10'd0) && (y_in == 10'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= 24'd0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else if (w_advance) begin
      m_tvalid <= r_s1_valid;
      m_tdata  <= {scale(r_s1_r, r_s1_k), scale(r_s1_g, r_s1_k), scale(r_s1_b, r_s1_k)};
      m_tlast  <= r_s1_last;
      m_tuser  <= r_s1_sof;
    end
  end

endmodule

// File: doc/rainbow_colour_gen.md
# rainbow_colour_gen

Downstream stage of the pixel coordinate counter in the rainbow test path. It consumes the (X, Y) pair for every pixel and produces a 24-bit RGB rainbow pixel on a valid/ready stream for the video output. The block is a 2-stage pipeline: hue ramp generation, then vertical brightness scaling. It emits start-of-frame and end-of-line markers and back-pressures the counter through in_ready.

## Interface
- LINE_LAST, default 1023: X value that marks the last pixel of a line.
- BRIGHT_EN, default 1: 1 enables Y-based brightness scaling; 0 forces full brightness.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- x_in  in  10  pixel column from the coordinate counter.
- y_in  in  10  pixel row from the coordinate counter (0..767).
- in_valid  in  1  x_in/y_in are valid this cycle.
- in_ready  out  1  block accepts x_in/y_in this cycle; drives the counter's enable.
- m_tdata  out  24  pixel {R[23:16], G[15:8], B[7:0]}.
- m_tvalid  out  1  m_tdata and markers are valid.
- m_tready  in  1  sink accepts the output pixel.
- m_tlast  out  1  pixel is the last of its line (x == LINE_LAST).
- m_tuser  out  1  pixel is the first of the frame (x == 0 and y == 0).

## Operation
- Pipeline control: advance = !m_tvalid || m_tready; in_ready = advance (combinational). Both stages move only when advance = 1.
- Stage 1 captures x_in and y_in when in_valid && advance, and sets s1_valid = in_valid on every advance.
- Stage 1 hue, with p = x_in:
  - seg = p[9:7]; r = {p[6:0], 1'b0} (0..254); nr = 255 - r (1..255).
  - seg 0: (255, r, 0)
  - seg 1: (nr, 255, 0)
  - seg 2: (0, 255, r)
  - seg 3: (0, nr, 255)
  - seg 4: (r, 0, 255)
  - seg 5: (255, 0, nr)
  - seg 6: (r, r, r)
  - seg 7: (nr, nr, nr)
- Stage 1 scale: k = 256 - y_in[9:2] (9 bits, 65..256). When BRIGHT_EN = 0, k = 256.
- Stage 1 markers: last = (x_in == LINE_LAST); sof = (x_in == 0 && y_in == 0).
- Stage 2 computes each channel out = (c * k) >> 8 with a 17-bit product and keeps bits [15:8]. The result is never above 255, so no saturation is needed.
- Stage 2 registers the result into m_tdata, with m_tvalid = s1_valid, m_tlast = last and m_tuser = sof, on each advance.
- Y values above 767 are not checked; the formula is applied as is.

## Timing
- Reset: s1_valid, m_tvalid, m_tlast, m_tuser and m_tdata all clear to 0. in_ready = 1 from the first cycle after reset.
- Latency: a pixel accepted at edge N appears on m_tvalid at edge N+2 when there is no back-pressure.
- Throughput: 1 pixel per cycle while m_tready = 1.
- Back-pressure:
  - While m_tvalid && !m_tready, all stage registers and outputs hold.
  - in_ready = 0 in the same cycle, so the counter does not advance.
  - No pixel is dropped or duplicated.
- Handshake: m_tdata, m_tlast and m_tuser stay stable while m_tvalid = 1 and m_tready = 0.
- Bubbles: in_valid = 0 while advancing inserts a bubble, and m_tvalid = 0 two advances later.
- Reset mid-stream: rst has priority over advance. In-flight pixels are discarded, and the next cycle shows m_tvalid = 0.
- Wrap-around: x = 1023 → 0 on the input needs no special handling. m_tlast is asserted on x = 1023 regardless of y.

## Test plan
- Reset, then in_valid = 1 with x = 0, y = 0 -> two cycles later m_tdata = 0xFF0000, m_tuser = 1, m_tlast = 0; in_ready = 1 throughout.
- x = 200, y = 400, BRIGHT_EN = 1 -> R = (111 * 156) >> 8 = 67, G = 155, B = 0, so m_tdata = 0x439B00.
- x = 1023, y = 767 -> seg 7, r = 254, nr = 1, k = 65 -> m_tdata = 0x000000, m_tlast = 1. Repeat with BRIGHT_EN = 0 -> 0x010101.
- Stream x = 0..1023 at y = 0 with m_tready = 1 -> 1024 consecutive beats, exactly one tlast on the final beat, and the channel sequence follows the segment table (x = 128 -> 0xFFFF00).
- Hold m_tready = 0 for 5 cycles mid-line -> in_ready = 0 and output stable for all 5 cycles; after release the x sequence resumes with no gap or repeat.
- Assert rst for 1 cycle with both stages full -> next cycle m_tvalid = 0 and m_tdata = 0. The first new pixel appears 2 cycles after it is presented.
